mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave Avalon-MM arbiter that lets the CPU's instruction-fetch port (pc) and load/store port (ldst) share a single on-chip memory. Sits between `cpu` and the memory. It serialises accesses, stalls the losing master through its waitrequest, and routes read data back to the correct master. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- STARVE_LIMIT, 4: consecutive ldst grants allowed while pc is pending before pc is forced a grant (>=1).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- i_pc_addr  in  32  fetch address.
- i_pc_rd  in  1  fetch read request.
- i_pc_byte_en  in  4  fetch byte enables.
- o_pc_rddata  out  32  fetch read data, valid when the read completes.
- o_pc_waitrequest  out  1  stall to fetch master.
- i_ldst_addr  in  32  load/store address.
- i_ldst_rd  in  1  load request.
- i_ldst_wr  in  1  store request.
- i_ldst_wrdata  in  32  store data.
- i_ldst_byte_en  in  4  load/store byte enables.
- o_ldst_rddata  out  32  load data, valid when the read completes.
- o_ldst_waitrequest  out  1  stall to load/store master.
- o_mem_addr, o_mem_wrdata  out  32  to memory.
- o_mem_rd, o_mem_wr  out  1  memory strobes.
- o_mem_byte_en  out  4  memory byte enables.
- i_mem_rddata  in  32  memory read data, fixed latency 1 after acceptance.
- i_mem_waitrequest  in  1  memory stall.

## Operation
- States: IDLE, GRANT_PC, GRANT_LDST, RESP_PC, RESP_LDST.
- IDLE: samples requests. pc_req = i_pc_rd; ldst_req = i_ldst_rd | i_ldst_wr.
  - ldst_req only: go to GRANT_LDST.
  - pc_req only: go to GRANT_PC.
  - Both, and starve_cnt < STARVE_LIMIT: go to GRANT_LDST.
  - Both, and starve_cnt == STARVE_LIMIT: go to GRANT_PC.
  - Neither: stay in IDLE.
- GRANT_x: the mem port is driven combinationally from the granted master's live inputs. Masters hold their signals stable while their waitrequest is high.
  - Stay in GRANT_x while i_mem_waitrequest = 1.
  - On acceptance (waitrequest = 0):
    - Read: go to RESP_x.
    - ldst write: the write completes this cycle; go to IDLE.
- RESP_x: register i_mem_rddata into o_x_rddata, then go to IDLE. o_x_rddata is registered and holds its last value until the next read for that master.
- ldst with i_ldst_rd and i_ldst_wr both high: treated as a write.
- o_x_waitrequest = request_x & ~done_x.
  - done_pc is high in the cycle after RESP_PC.
  - done_ldst is high on write acceptance, or in the cycle after RESP_LDST.
  - Result: waitrequest is low whenever that master is idle, and low exactly in the completion cycle, when rddata is valid.
- Memory outputs are 0 in IDLE and RESP states: rd = wr = 0, addr/wrdata/byte_en = 0.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - increments (saturating) on each entry to GRANT_LDST while pc_req = 1;
  - clears on entry to GRANT_PC;
  - otherwise holds.

## Timing
- Reset (reset = 0): state goes to IDLE immediately (asynchronous). starve_cnt = 0, both rddata = 0, mem strobes = 0. Each waitrequest follows its request (high if requesting).
- Reset mid-transaction: strobes drop the same instant, and the in-flight access is abandoned. After release, pending requests are re-arbitrated from IDLE.
- Minimum latency, request assert to completion cycle, with i_mem_waitrequest = 0:
  - write: 2 cycles (IDLE, GRANT);
  - read: 4 cycles (IDLE, GRANT, RESP, completion).
- Each cycle of i_mem_waitrequest = 1 adds one cycle.
- Back-to-back: a master that keeps its request asserted after completion is re-arbitrated in the following IDLE cycle. No grant is held across IDLE.
- The non-granted master's waitrequest stays high for the whole of the other master's transaction.

## Test plan
- Single fetch: i_pc_rd = 1, addr 0x0, memory returns 0x00402503 one cycle after acceptance. Required: o_pc_waitrequest low exactly in the 4th cycle, with o_pc_rddata = 0x00402503.
- Load with memory stall: i_ldst_rd at 0x4, i_mem_waitrequest = 1 for 20 cycles, then 0 with data 0x12345678.
  - o_ldst_waitrequest stays high throughout the stall.
  - o_mem_addr holds 0x4.
  - On completion, o_ldst_rddata = 0x12345678.
- Store: i_ldst_wr = 1, addr 0x8, data 0x12345678, byte_en 0xF. Required: o_mem_wr = 1 with matching addr/data, and o_ldst_waitrequest low in the 2nd cycle. o_mem_rd never asserts.
- Contention and starvation, with STARVE_LIMIT = 4 and both masters requesting continuously:
  - grant order is ldst ×4, pc, ldst ×4, pc, …;
  - pc is never starved beyond 4 ldst grants.
- Reset mid-read: assert reset during GRANT_PC while i_mem_waitrequest = 1.
  - o_mem_rd drops without waiting for a clock edge, and o_pc_rddata = 0.
  - After release, the fetch is reissued and completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch (pc) port, load/store (ldst) port and
// the shared memory port. "slave" is the arbiter's view; "master" is the
// view of the surrounding CPU and memory that drive the arbiter's inputs.
interface mem_arbiter_if;
   logic [31:0] i_pc_addr;
   logic        i_pc_rd;
   logic [3:0]  i_pc_byte_en;
   logic [31:0] o_pc_rddata;
   logic        o_pc_waitrequest;

   logic [31:0] i_ldst_addr;
   logic        i_ldst_rd;
   logic        i_ldst_wr;
   logic [31:0] i_ldst_wrdata;
   logic [3:0]  i_ldst_byte_en;
   logic [31:0] o_ldst_rddata;
   logic        o_ldst_waitrequest;

   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wrdata;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic [3:0]  o_mem_byte_en;
   logic [31:0] i_mem_rddata;
   logic        i_mem_waitrequest;

   modport slave (
      input  i_pc_addr, i_pc_rd, i_pc_byte_en,
      output o_pc_rddata, o_pc_waitrequest,
      input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
      output o_ldst_rddata, o_ldst_waitrequest,
      output o_mem_addr, o_mem_wrdata, o_mem_rd, o_mem_wr, o_mem_byte_en,
      input  i_mem_rddata, i_mem_waitrequest
   );

   modport master (
      output i_pc_addr, i_pc_rd, i_pc_byte_en,
      input  o_pc_rddata, o_pc_waitrequest,
      output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
      input  o_ldst_rddata, o_ldst_waitrequest,
      input  o_mem_addr, o_mem_wrdata, o_mem_rd, o_mem_wr, o_mem_byte_en,
      output i_mem_rddata, i_mem_waitrequest
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master Avalon-MM arbiter: CPU fetch (pc) and load/store (ldst) share
// one memory with fixed read latency 1. ldst has priority; a starvation
// counter forces a pc grant after STARVE_LIMIT consecutive ldst grants
// taken while pc was waiting. One access at a time, re-arbitrated in IDLE.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] GRANT_PC   = 3'd1;
   localparam logic [2:0] GRANT_LDST = 3'd2;
   localparam logic [2:0] RESP_PC    = 3'd3;
   localparam logic [2:0] RESP_LDST  = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             done_pc_q;
   logic             done_ldst_q;
   logic [31:0]      pc_rddata;
   logic [31:0]      ldst_rddata;

   logic pc_req;
   logic ldst_req;
   logic ldst_is_wr;
   logic mem_accept;
   logic pc_pend;
   logic ldst_pend;
   logic done_ldst;

   assign pc_req     = bus.i_pc_rd;
   assign ldst_req   = bus.i_ldst_rd | bus.i_ldst_wr;
   assign ldst_is_wr = bus.i_ldst_wr;   // rd+wr together counts as a write
   assign mem_accept = ~bus.i_mem_waitrequest;

   // In a read's completion cycle the master still shows the request it is
   // being released from; it must not win a second grant for it.
   assign pc_pend   = pc_req & ~done_pc_q;
   assign ldst_pend = ldst_req & ~done_ldst_q;

   // Next-state selection: ldst first unless pc has waited STARVE_LIMIT grants.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ldst_pend && pc_pend)
               state_nxt = (starve_cnt >= CNT_MAX) ? GRANT_PC : GRANT_LDST;
            else if (ldst_pend)
               state_nxt = GRANT_LDST;
            else if (pc_pend)
               state_nxt = GRANT_PC;
         end
         GRANT_PC: begin
            if (mem_accept)
               state_nxt = RESP_PC;
         end
         GRANT_LDST: begin
            if (mem_accept)
               state_nxt = ldst_is_wr ? IDLE : RESP_LDST;
         end
         RESP_PC:   state_nxt = IDLE;
         RESP_LDST: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any in-flight access immediately.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignments for all clocked state to avoid update-order races.
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Starvation counter: counts ldst grants taken while pc was requesting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (state == IDLE && state_nxt == GRANT_PC) begin
         starve_cnt <= '0;
      end else if (state == IDLE && state_nxt == GRANT_LDST && pc_req &&
                   starve_cnt < CNT_MAX) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Completion flags for reads: high in the cycle after the response state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_pc_q   <= 1'b0;
         done_ldst_q <= 1'b0;
      end else begin
         done_pc_q   <= (state == RESP_PC);
         done_ldst_q <= (state == RESP_LDST);
      end
   end

   // Read-data capture; each register holds until that master's next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_rddata   <= '0;
         ldst_rddata <= '0;
      end else begin
         if (state == RESP_PC)
            pc_rddata <= bus.i_mem_rddata;
         if (state == RESP_LDST)
            ldst_rddata <= bus.i_mem_rddata;
      end
   end

   // Writes complete in their acceptance cycle, reads one cycle after RESP.
   assign done_ldst = done_ldst_q |
                      ((state == GRANT_LDST) & ldst_is_wr & mem_accept);

   assign bus.o_pc_rddata        = pc_rddata;
   assign bus.o_ldst_rddata      = ldst_rddata;
   assign bus.o_pc_waitrequest   = pc_req & ~done_pc_q;
   assign bus.o_ldst_waitrequest = ldst_req & ~done_ldst;

   // Memory port mux: granted master's live signals, all zero otherwise.
   always_comb begin
      bus.o_mem_addr    = '0;
      bus.o_mem_wrdata  = '0;
      bus.o_mem_rd      = 1'b0;
      bus.o_mem_wr      = 1'b0;
      bus.o_mem_byte_en = '0;
      case (state)
         GRANT_PC: begin
            bus.o_mem_addr    = bus.i_pc_addr;
            bus.o_mem_rd      = 1'b1;
            bus.o_mem_byte_en = bus.i_pc_byte_en;
         end
         GRANT_LDST: begin
            bus.o_mem_addr    = bus.i_ldst_addr;
            bus.o_mem_wrdata  = bus.i_ldst_wrdata;
            bus.o_mem_wr      = ldst_is_wr;
            bus.o_mem_rd      = ~ldst_is_wr;
            bus.o_mem_byte_en = bus.i_ldst_byte_en;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single fetch, stalled load,
// stores, fetch/load contention with starvation, reset mid-read.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   tests_run    = 0;
   int   tests_failed = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory contents as seen by the bench.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0:   return 32'h00402503;
         32'h4:   return 32'h12345678;
         default: return {addr[15:0], 16'hC0DE};
      endcase
   endfunction

   // Memory model: read data appears one cycle after an accepted read.
   always @(posedge clk)
      bus.i_mem_rddata <= (bus.o_mem_rd && !bus.i_mem_waitrequest) ?
                          mem_word(bus.o_mem_addr) : 32'hDEADBEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] order;
      int         n_grants;

      reset                 = 1'b0;
      bus.i_pc_addr         = '0;
      bus.i_pc_rd           = 1'b1;
      bus.i_pc_byte_en      = 4'hF;
      bus.i_ldst_addr       = '0;
      bus.i_ldst_rd         = 1'b0;
      bus.i_ldst_wr         = 1'b0;
      bus.i_ldst_wrdata     = '0;
      bus.i_ldst_byte_en    = '0;
      bus.i_mem_waitrequest = 1'b0;

      // ---------------- reset state ----------------
      step(); step(); #1;
      check("rst pc_wait", bus.o_pc_waitrequest, 1);
      check("rst ldst_wait", bus.o_ldst_waitrequest, 0);
      check("rst mem_rd", bus.o_mem_rd, 0);
      check("rst mem_wr", bus.o_mem_wr, 0);
      check("rst pc_rddata", bus.o_pc_rddata, 0);
      check("rst ldst_rddata", bus.o_ldst_rddata, 0);
      bus.i_pc_rd = 1'b0;
      #1;
      check("rst pc_wait idle", bus.o_pc_waitrequest, 0);
      reset = 1'b1;

      // ---------------- single fetch ----------------
      step();
      bus.i_pc_rd = 1'b1; bus.i_pc_addr = 32'h0; bus.i_pc_byte_en = 4'hF;
      #1;
      check("fetch c1 wait", bus.o_pc_waitrequest, 1);
      check("fetch c1 mem_rd", bus.o_mem_rd, 0);
      step(); #1;
      check("fetch c2 wait", bus.o_pc_waitrequest, 1);
      check("fetch c2 mem_rd", bus.o_mem_rd, 1);
      check("fetch c2 addr", bus.o_mem_addr, 32'h0);
      check("fetch c2 be", bus.o_mem_byte_en, 4'hF);
      check("fetch c2 mem_wr", bus.o_mem_wr, 0);
      step(); #1;
      check("fetch c3 wait", bus.o_pc_waitrequest, 1);
      check("fetch c3 mem_rd", bus.o_mem_rd, 0);
      step(); #1;
      check("fetch c4 wait", bus.o_pc_waitrequest, 0);
      check("fetch c4 rddata", bus.o_pc_rddata, 32'h00402503);
      step();
      bus.i_pc_rd = 1'b0;
      #1;
      check("fetch no regrant", bus.o_mem_rd, 0);

      // ---------------- load with 20-cycle memory stall ----------------
      step();
      bus.i_ldst_rd = 1'b1; bus.i_ldst_addr = 32'h4; bus.i_ldst_byte_en = 4'hF;
      bus.i_mem_waitrequest = 1'b1;
      #1;
      check("load c1 wait", bus.o_ldst_waitrequest, 1);
      check("load c1 mem_rd", bus.o_mem_rd, 0);
      for (int i = 0; i < 20; i++) begin
         step(); #1;
         check("load stall wait", bus.o_ldst_waitrequest, 1);
         check("load stall addr", bus.o_mem_addr, 32'h4);
         check("load stall mem_rd", bus.o_mem_rd, 1);
      end
      step();
      bus.i_mem_waitrequest = 1'b0;
      #1;
      check("load accept mem_rd", bus.o_mem_rd, 1);
      check("load accept wait", bus.o_ldst_waitrequest, 1);
      step(); #1;
      check("load resp wait", bus.o_ldst_waitrequest, 1);
      check("load resp mem_rd", bus.o_mem_rd, 0);
      check("load resp addr", bus.o_mem_addr, 0);
      step(); #1;
      check("load done wait", bus.o_ldst_waitrequest, 0);
      check("load done rddata", bus.o_ldst_rddata, 32'h12345678);
      step();
      bus.i_ldst_rd = 1'b0;
      #1;
      check("load no regrant", bus.o_mem_rd, 0);

      // ---------------- store ----------------
      step();
      bus.i_ldst_wr = 1'b1; bus.i_ldst_addr = 32'h8;
      bus.i_ldst_wrdata = 32'h12345678; bus.i_ldst_byte_en = 4'hF;
      #1;
      check("store c1 wait", bus.o_ldst_waitrequest, 1);
      check("store c1 mem_wr", bus.o_mem_wr, 0);
      step(); #1;
      check("store c2 mem_wr", bus.o_mem_wr, 1);
      check("store c2 mem_rd", bus.o_mem_rd, 0);
      check("store c2 addr", bus.o_mem_addr, 32'h8);
      check("store c2 data", bus.o_mem_wrdata, 32'h12345678);
      check("store c2 be", bus.o_mem_byte_en, 4'hF);
      check("store c2 wait", bus.o_ldst_waitrequest, 0);
      step();
      bus.i_ldst_wr = 1'b0;
      #1;
      check("store idle mem_wr", bus.o_mem_wr, 0);
      check("store idle mem_rd", bus.o_mem_rd, 0);
      check("store rddata hold", bus.o_ldst_rddata, 32'h12345678);

      // ---------------- rd and wr together: treated as a write ----------------
      step();
      bus.i_ldst_rd = 1'b1; bus.i_ldst_wr = 1'b1; bus.i_ldst_addr = 32'hC;
      bus.i_ldst_wrdata = 32'hCAFEF00D; bus.i_ldst_byte_en = 4'h3;
      #1;
      check("rdwr c1 wait", bus.o_ldst_waitrequest, 1);
      step(); #1;
      check("rdwr mem_wr", bus.o_mem_wr, 1);
      check("rdwr mem_rd", bus.o_mem_rd, 0);
      check("rdwr data", bus.o_mem_wrdata, 32'hCAFEF00D);
      check("rdwr be", bus.o_mem_byte_en, 4'h3);
      check("rdwr wait", bus.o_ldst_waitrequest, 0);
      step();
      bus.i_ldst_rd = 1'b0; bus.i_ldst_wr = 1'b0;

      // ---------------- contention and starvation ----------------
      step();
      bus.i_pc_rd = 1'b1; bus.i_pc_addr = 32'h10; bus.i_pc_byte_en = 4'hF;
      bus.i_ldst_wr = 1'b1; bus.i_ldst_addr = 32'h40;
      bus.i_ldst_wrdata = 32'h55AA55AA; bus.i_ldst_byte_en = 4'hF;
      order    = '0;
      n_grants = 0;
      for (int cyc = 0; cyc < 60 && n_grants < 10; cyc++) begin
         #1;
         if (bus.o_mem_wr) begin
            order[n_grants] = 1'b0;
            n_grants++;
            check("contend pc_wait", bus.o_pc_waitrequest, 1);
         end else if (bus.o_mem_rd) begin
            order[n_grants] = 1'b1;
            n_grants++;
            check("contend ldst_wait", bus.o_ldst_waitrequest, 1);
         end
         @(posedge clk);
      end
      check("contend grant count", n_grants, 10);
      check("contend grant order", {22'd0, order}, 32'h210);
      #1;
      bus.i_ldst_wr = 1'b0;
      #1;
      check("contend resp mem_rd", bus.o_mem_rd, 0);
      step(); #1;
      check("contend pc done wait", bus.o_pc_waitrequest, 0);
      check("contend pc rddata", bus.o_pc_rddata, 32'h0010C0DE);
      step();
      bus.i_pc_rd = 1'b0;

      // ---------------- reset during a stalled fetch ----------------
      step();
      bus.i_pc_rd = 1'b1; bus.i_pc_addr = 32'h20; bus.i_mem_waitrequest = 1'b1;
      step(); #1;
      check("rstmid grant mem_rd", bus.o_mem_rd, 1);
      #1;
      reset = 1'b0;
      #1;
      check("rstmid mem_rd drop", bus.o_mem_rd, 0);
      check("rstmid pc_rddata", bus.o_pc_rddata, 0);
      check("rstmid pc_wait", bus.o_pc_waitrequest, 1);
      step();
      reset = 1'b1;
      bus.i_mem_waitrequest = 1'b0;
      #1;
      check("rstmid idle mem_rd", bus.o_mem_rd, 0);
      check("rstmid idle wait", bus.o_pc_waitrequest, 1);
      step(); #1;
      check("rstmid reissue mem_rd", bus.o_mem_rd, 1);
      check("rstmid reissue addr", bus.o_mem_addr, 32'h20);
      step(); #1;
      check("rstmid resp wait", bus.o_pc_waitrequest, 1);
      step(); #1;
      check("rstmid done wait", bus.o_pc_waitrequest, 0);
      check("rstmid done rddata", bus.o_pc_rddata, 32'h0020C0DE);
      step();
      bus.i_pc_rd = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
